// File: rtl/bus_pkg.sv
// Shared encodings and sizing helpers for the master/slave interconnect arbiters.
package bus_pkg;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [1:0] RESP_RETRY = 2'b10;
  localparam logic [1:0] RESP_SPLIT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10
  } bus_state_e;

  // Index width for n items, never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after ptr_i, wrapping.
module rr_pick import bus_pkg::*; #(
  parameter int N = 2,
  parameter int W = idx_width(N)
) (
  input  logic [N-1:0] eligible_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] grant_o,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  logic [2*N-1:0] dbl_s;
  logic [N-1:0]   rot_s;
  logic [W-1:0]   off_s;
  logic [W:0]     sum_s;

  // Rotate so bit 0 sits at the pointer, take the lowest set bit, then rotate the index back.
  always_comb begin
    dbl_s = {eligible_i, eligible_i} >> ptr_i;
    rot_s = dbl_s[N-1:0];
    off_s = {W{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      off_s = rot_s[k] ? W'(k) : off_s;
    end
    sum_s = {1'b0, ptr_i} + {1'b0, off_s};
    if (sum_s >= (W+1)'(N)) begin
      idx_o = W'(sum_s - (W+1)'(N));
    end else begin
      idx_o = sum_s[W-1:0];
    end
    valid_o = |rot_s;
    grant_o = valid_o ? ({{(N-1){1'b0}}, 1'b1} << idx_o) : {N{1'b0}};
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter and transfer controller: IDLE/ADDR/DATA sequencing,
// response handling with split masking, and a data-phase wait-state timeout.
module bus_arbiter_rr import bus_pkg::*; #(
  parameter int  N_MASTERS = 2,
  parameter int  N_SLAVES  = 2,
  parameter int  TIMEOUT   = 16,
  localparam int MW        = idx_width(N_MASTERS),
  localparam int SW        = idx_width(N_SLAVES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_MASTERS-1:0]    busreq,
  input  logic [N_MASTERS-1:0]    rw,
  input  logic [N_MASTERS*SW-1:0] slv_id,
  input  logic                    ready,
  input  logic [1:0]              resp,
  input  logic [N_MASTERS-1:0]    split_resume,
  output logic [N_MASTERS-1:0]    grant,
  output logic [MW-1:0]           mst_sel,
  output logic [N_SLAVES-1:0]     slv_sel,
  output logic                    addr_en,
  output logic                    wdata_en,
  output logic                    rdata_en,
  output logic                    done,
  output logic                    error,
  output logic                    timeout
);

  localparam int CW = idx_width(TIMEOUT);

  bus_state_e           state_q;
  logic [MW-1:0]        rr_ptr_q;
  logic [N_MASTERS-1:0] split_mask_q;
  logic [CW-1:0]        wait_cnt_q;
  logic                 rw_q;
  logic [N_MASTERS-1:0] grant_q;
  logic [MW-1:0]        mst_sel_q;
  logic [N_SLAVES-1:0]  slv_sel_q;
  logic                 addr_en_q;
  logic                 wdata_en_q;
  logic                 rdata_en_q;
  logic                 done_q;
  logic                 error_q;
  logic                 timeout_q;

  logic [N_MASTERS-1:0] eligible_s;
  logic [N_MASTERS-1:0] pick_grant_s;
  logic [MW-1:0]        pick_idx_s;
  logic                 pick_valid_s;
  logic [SW-1:0]        pick_slv_s;
  logic                 pick_rw_s;
  logic                 pick_bad_s;
  logic [MW-1:0]        pick_next_s;
  logic [MW-1:0]        cur_next_s;
  logic [N_SLAVES-1:0]  slv_onehot_s;
  logic [N_MASTERS-1:0] mask_resumed_s;
  logic                 dat_done_s;
  logic                 dat_err_s;
  logic                 dat_retry_s;
  logic                 dat_split_s;
  logic                 dat_tmo_s;
  logic                 dat_end_s;
  logic                 dat_adv_s;

  assign eligible_s = busreq & ~split_mask_q;

  rr_pick #(
    .N (N_MASTERS),
    .W (MW)
  ) u_pick (
    .eligible_i (eligible_s),
    .ptr_i      (rr_ptr_q),
    .grant_o    (pick_grant_s),
    .idx_o      (pick_idx_s),
    .valid_o    (pick_valid_s)
  );

  // Per-master attributes of the arbitration winner and the wrapped successor pointers.
  always_comb begin
    pick_slv_s = {SW{1'b0}};
    pick_rw_s  = 1'b0;
    for (int m = 0; m < N_MASTERS; m++) begin
      pick_slv_s = (pick_idx_s == MW'(m)) ? slv_id[m*SW +: SW] : pick_slv_s;
      pick_rw_s  = (pick_idx_s == MW'(m)) ? rw[m] : pick_rw_s;
    end
    pick_bad_s     = ({1'b0, pick_slv_s} >= (SW+1)'(N_SLAVES));
    slv_onehot_s   = {{(N_SLAVES-1){1'b0}}, 1'b1} << pick_slv_s;
    pick_next_s    = (pick_idx_s == MW'(N_MASTERS - 1)) ? {MW{1'b0}} : pick_idx_s + MW'(1'b1);
    cur_next_s     = (mst_sel_q == MW'(N_MASTERS - 1)) ? {MW{1'b0}} : mst_sel_q + MW'(1'b1);
    mask_resumed_s = split_mask_q & ~split_resume;
  end

  // Data-phase outcome; response codes are mutually exclusive, wait/timeout is the fallback.
  always_comb begin
    dat_done_s  = ready & (resp == RESP_OKAY);
    dat_err_s   = (resp == RESP_ERROR);
    dat_retry_s = ready & (resp == RESP_RETRY);
    dat_split_s = ready & (resp == RESP_SPLIT);
    dat_tmo_s   = ~(dat_done_s | dat_err_s | dat_retry_s | dat_split_s) &
                  (wait_cnt_q == CW'(TIMEOUT - 1));
    dat_end_s   = dat_done_s | dat_err_s | dat_retry_s | dat_split_s | dat_tmo_s;
    dat_adv_s   = dat_done_s | dat_err_s | dat_split_s | dat_tmo_s;
  end

  // Controller FSM, round-robin pointer, split mask and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= {MW{1'b0}};
      split_mask_q <= {N_MASTERS{1'b0}};
      wait_cnt_q   <= {CW{1'b0}};
      rw_q         <= 1'b0;
      grant_q      <= {N_MASTERS{1'b0}};
      mst_sel_q    <= {MW{1'b0}};
      slv_sel_q    <= {N_SLAVES{1'b0}};
      addr_en_q    <= 1'b0;
      wdata_en_q   <= 1'b0;
      rdata_en_q   <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      timeout_q    <= 1'b0;
      split_mask_q <= mask_resumed_s;
      case (state_q)
        IDLE: begin
          if (pick_valid_s && pick_bad_s) begin
            // Undecodable target: refuse the bus and move on to the next master.
            error_q  <= 1'b1;
            rr_ptr_q <= pick_next_s;
          end else if (pick_valid_s) begin
            state_q   <= ADDR;
            grant_q   <= pick_grant_s;
            mst_sel_q <= pick_idx_s;
            slv_sel_q <= slv_onehot_s;
            addr_en_q <= 1'b1;
            rw_q      <= pick_rw_s;
          end
        end
        ADDR: begin
          state_q    <= DATA;
          addr_en_q  <= 1'b0;
          wdata_en_q <= rw_q;
          rdata_en_q <= ~rw_q;
          wait_cnt_q <= {CW{1'b0}};
        end
        DATA: begin
          if (dat_end_s) begin
            state_q    <= IDLE;
            grant_q    <= {N_MASTERS{1'b0}};
            mst_sel_q  <= {MW{1'b0}};
            slv_sel_q  <= {N_SLAVES{1'b0}};
            wdata_en_q <= 1'b0;
            rdata_en_q <= 1'b0;
            done_q     <= dat_done_s;
            error_q    <= dat_err_s | dat_tmo_s;
            timeout_q  <= dat_tmo_s;
            if (dat_adv_s) begin
              rr_ptr_q <= cur_next_s;
            end
            if (dat_split_s) begin
              split_mask_q <= mask_resumed_s | grant_q;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1'b1);
          end
        end
        default: begin
          state_q    <= IDLE;
          grant_q    <= {N_MASTERS{1'b0}};
          mst_sel_q  <= {MW{1'b0}};
          slv_sel_q  <= {N_SLAVES{1'b0}};
          addr_en_q  <= 1'b0;
          wdata_en_q <= 1'b0;
          rdata_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign grant    = grant_q;
  assign mst_sel  = mst_sel_q;
  assign slv_sel  = slv_sel_q;
  assign addr_en  = addr_en_q;
  assign wdata_en = wdata_en_q;
  assign rdata_en = rdata_en_q;
  assign done     = done_q;
  assign error    = error_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: a 2-master/2-slave instance and a 4-master/3-slave instance.
module tb_bus_arbiter_rr;
  import bus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rst;
  logic [1:0] busreq, rw, slv_id, split_resume, resp;
  logic       ready;
  logic [1:0] grant, slv_sel;
  logic [0:0] mst_sel;
  logic       addr_en, wdata_en, rdata_en, done, error, timeout;

  logic [3:0] busreq4, rw4, split_resume4, grant4;
  logic [7:0] slv_id4;
  logic [1:0] resp4, mst_sel4;
  logic       ready4;
  logic [2:0] slv_sel4;
  logic       addr_en4, wdata_en4, rdata_en4, done4, error4, timeout4;

  bus_arbiter_rr #(.N_MASTERS(2), .N_SLAVES(2), .TIMEOUT(16)) u_dut (
    .clk(clk), .rst(rst), .busreq(busreq), .rw(rw), .slv_id(slv_id), .ready(ready),
    .resp(resp), .split_resume(split_resume), .grant(grant), .mst_sel(mst_sel),
    .slv_sel(slv_sel), .addr_en(addr_en), .wdata_en(wdata_en), .rdata_en(rdata_en),
    .done(done), .error(error), .timeout(timeout)
  );

  bus_arbiter_rr #(.N_MASTERS(4), .N_SLAVES(3), .TIMEOUT(4)) u_dut4 (
    .clk(clk), .rst(rst), .busreq(busreq4), .rw(rw4), .slv_id(slv_id4), .ready(ready4),
    .resp(resp4), .split_resume(split_resume4), .grant(grant4), .mst_sel(mst_sel4),
    .slv_sel(slv_sel4), .addr_en(addr_en4), .wdata_en(wdata_en4), .rdata_en(rdata_en4),
    .done(done4), .error(error4), .timeout(timeout4)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // fl = {addr_en, wdata_en, rdata_en, done, error, timeout}
  task automatic chk2(input string tag, input logic [1:0] g, input logic ms,
                      input logic [1:0] ss, input logic [5:0] fl);
    check_eq(tag, {21'd0, grant, mst_sel, slv_sel, addr_en, wdata_en, rdata_en, done, error, timeout},
             {21'd0, g, ms, ss, fl});
  endtask

  task automatic chk4(input string tag, input logic [3:0] g, input logic [1:0] ms,
                      input logic [2:0] ss, input logic [5:0] fl);
    check_eq(tag, {17'd0, grant4, mst_sel4, slv_sel4, addr_en4, wdata_en4, rdata_en4, done4, error4, timeout4},
             {17'd0, g, ms, ss, fl});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; busreq = 2'b00; rw = 2'b00; slv_id = 2'b00; ready = 1'b0;
    resp = RESP_OKAY; split_resume = 2'b00;
    busreq4 = 4'b0000; rw4 = 4'b1000; slv_id4 = 8'b10_00_11_01; ready4 = 1'b1;
    resp4 = RESP_OKAY; split_resume4 = 4'b0000;
    tick(); tick();
    chk2("reset", 2'b00, 1'b0, 2'b00, 6'b000000);
    chk4("reset4", 4'b0000, 2'd0, 3'b000, 6'b000000);

    // m0 writes slave 1, m1 reads slave 0, all zero-wait OKAY
    rst = 1'b1; busreq = 2'b11; rw = 2'b01; slv_id = 2'b01; ready = 1'b1;
    tick(); chk2("t1_addr", 2'b01, 1'b0, 2'b10, 6'b100000);
    tick(); chk2("t1_data", 2'b01, 1'b0, 2'b10, 6'b010000);
    tick(); chk2("t1_done", 2'b00, 1'b0, 2'b00, 6'b000100);
    tick(); chk2("t2_addr", 2'b10, 1'b1, 2'b01, 6'b100000);
    tick(); chk2("t2_data", 2'b10, 1'b1, 2'b01, 6'b001000);
    tick(); chk2("t2_done", 2'b00, 1'b0, 2'b00, 6'b000100);
    tick(); chk2("t3_addr", 2'b01, 1'b0, 2'b10, 6'b100000);
    resp = RESP_RETRY;
    tick(); chk2("t3_data", 2'b01, 1'b0, 2'b10, 6'b010000);
    tick(); chk2("t3_retry", 2'b00, 1'b0, 2'b00, 6'b000000);
    resp = RESP_OKAY;
    tick(); chk2("t4_regrant", 2'b01, 1'b0, 2'b10, 6'b100000);
    ready = 1'b0;
    tick(); chk2("t4_data", 2'b01, 1'b0, 2'b10, 6'b010000);
    for (int i = 0; i < 15; i++) begin
      tick(); chk2("t4_wait", 2'b01, 1'b0, 2'b10, 6'b010000);
    end
    tick(); chk2("t4_timeout", 2'b00, 1'b0, 2'b00, 6'b000011);

    // m1 gets SPLIT and stays masked until resumed
    ready = 1'b1; resp = RESP_SPLIT;
    tick(); chk2("t5_addr", 2'b10, 1'b1, 2'b01, 6'b100000);
    tick(); chk2("t5_data", 2'b10, 1'b1, 2'b01, 6'b001000);
    tick(); chk2("t5_split", 2'b00, 1'b0, 2'b00, 6'b000000);
    resp = RESP_OKAY;
    tick(); chk2("t6_addr", 2'b01, 1'b0, 2'b10, 6'b100000);
    tick(); chk2("t6_data", 2'b01, 1'b0, 2'b10, 6'b010000);
    tick(); chk2("t6_done", 2'b00, 1'b0, 2'b00, 6'b000100);
    busreq = 2'b10;
    tick(); chk2("t7_masked", 2'b00, 1'b0, 2'b00, 6'b000000);
    tick(); chk2("t7_masked2", 2'b00, 1'b0, 2'b00, 6'b000000);
    split_resume = 2'b10;
    tick(); chk2("t7_resume", 2'b00, 1'b0, 2'b00, 6'b000000);
    split_resume = 2'b00;
    tick(); chk2("t8_addr", 2'b10, 1'b1, 2'b01, 6'b100000);
    tick(); chk2("t8_data", 2'b10, 1'b1, 2'b01, 6'b001000);
    tick(); chk2("t8_done", 2'b00, 1'b0, 2'b00, 6'b000100);

    // ERROR with ready low still ends the transfer
    busreq = 2'b01; resp = RESP_ERROR; ready = 1'b0;
    tick(); chk2("t9_addr", 2'b01, 1'b0, 2'b10, 6'b100000);
    tick(); chk2("t9_data", 2'b01, 1'b0, 2'b10, 6'b010000);
    tick(); chk2("t9_error", 2'b00, 1'b0, 2'b00, 6'b000010);

    // split m1, then reset mid-transfer must clear the mask
    busreq = 2'b11; resp = RESP_SPLIT; ready = 1'b1;
    tick(); chk2("t10_addr", 2'b10, 1'b1, 2'b01, 6'b100000);
    tick(); chk2("t10_data", 2'b10, 1'b1, 2'b01, 6'b001000);
    tick(); chk2("t10_split", 2'b00, 1'b0, 2'b00, 6'b000000);
    resp = RESP_OKAY;
    tick(); chk2("t11_addr", 2'b01, 1'b0, 2'b10, 6'b100000);
    tick(); chk2("t11_data", 2'b01, 1'b0, 2'b10, 6'b010000);
    rst = 1'b0;
    tick(); chk2("rst_mid", 2'b00, 1'b0, 2'b00, 6'b000000);
    rst = 1'b1; busreq = 2'b10;
    tick(); chk2("t12_addr", 2'b10, 1'b1, 2'b01, 6'b100000);
    busreq = 2'b00;
    tick(); chk2("t12_data", 2'b10, 1'b1, 2'b01, 6'b001000);
    tick(); chk2("t12_done", 2'b00, 1'b0, 2'b00, 6'b000100);

    // 4 masters: wrap 3->0, undecodable slave, short timeout
    busreq4 = 4'b1000;
    tick(); chk4("w_addr", 4'b1000, 2'd3, 3'b100, 6'b100000);
    tick(); chk4("w_data", 4'b1000, 2'd3, 3'b100, 6'b010000);
    tick(); chk4("w_done", 4'b0000, 2'd0, 3'b000, 6'b000100);
    busreq4 = 4'b1011;
    tick(); chk4("w_wrap", 4'b0001, 2'd0, 3'b010, 6'b100000);
    tick(); chk4("w_data0", 4'b0001, 2'd0, 3'b010, 6'b001000);
    tick(); chk4("w_done0", 4'b0000, 2'd0, 3'b000, 6'b000100);
    tick(); chk4("bad_slave", 4'b0000, 2'd0, 3'b000, 6'b000010);
    tick(); chk4("bad_skip", 4'b1000, 2'd3, 3'b100, 6'b100000);
    ready4 = 1'b0;
    tick(); chk4("t4w_data", 4'b1000, 2'd3, 3'b100, 6'b010000);
    for (int i = 0; i < 3; i++) begin
      tick(); chk4("t4w_wait", 4'b1000, 2'd3, 3'b100, 6'b010000);
    end
    tick(); chk4("t4w_timeout", 4'b0000, 2'd0, 3'b000, 6'b000011);
    busreq4 = 4'b0000;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
